// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: prescaled ms/s/m counter chain driven by the mode
// controller, with a lap-freezable display copy and a sticky overflow flag.
module stopwatch_timebase #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       ms_tick,
    output logic       s_tick,
    output logic       m_tick,
    output logic [9:0] ms_cnt,
    output logic [5:0] sec_cnt,
    output logic [5:0] min_cnt,
    output logic [9:0] disp_ms,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO  = PW'(0);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [5:0]    MIN_LAST  = 6'(MIN_MAX);

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_LAP   = 2'b10;
    localparam logic [1:0] MODE_PAUSE = 2'b11;

    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    ms_q, ms_d, disp_ms_q, disp_ms_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [5:0]    disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
    logic          ms_tick_q, ms_tick_d, s_tick_q, s_tick_d, m_tick_q, m_tick_d;
    logic          running_q, running_d, lap_q, lap_d, ovf_q, ovf_d;

    // Next-state logic for prescaler, counter cascade, display copy and flags
    always_comb begin
        pre_d      = pre_q;
        ms_d       = ms_q;
        sec_d      = sec_q;
        min_d      = min_q;
        disp_ms_d  = disp_ms_q;
        disp_sec_d = disp_sec_q;
        disp_min_d = disp_min_q;
        ms_tick_d  = 1'b0;
        s_tick_d   = 1'b0;
        m_tick_d   = 1'b0;
        ovf_d      = ovf_q;
        running_d  = (mode == MODE_RUN) || (mode == MODE_LAP);
        lap_d      = (mode == MODE_LAP);

        case (mode)
            MODE_RUN, MODE_LAP: begin
                if (pre_q == PRE_LAST) begin
                    pre_d     = PRE_ZERO;
                    ms_tick_d = 1'b1;
                    if (ms_q == 10'd999) begin
                        ms_d     = 10'd0;
                        s_tick_d = 1'b1;
                        if (sec_q == 6'd59) begin
                            sec_d    = 6'd0;
                            m_tick_d = 1'b1;
                            if (min_q == MIN_LAST) begin
                                min_d = 6'd0;
                                ovf_d = 1'b1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        ms_d = ms_q + 10'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_ONE;
                end
                // Display samples pre-update live values; LAP freezes it.
                if (mode == MODE_RUN) begin
                    disp_ms_d  = ms_q;
                    disp_sec_d = sec_q;
                    disp_min_d = min_q;
                end else begin
                    disp_ms_d  = disp_ms_q;
                    disp_sec_d = disp_sec_q;
                    disp_min_d = disp_min_q;
                end
            end
            MODE_PAUSE: begin
                disp_ms_d  = ms_q;
                disp_sec_d = sec_q;
                disp_min_d = min_q;
            end
            MODE_STOP: begin
                pre_d      = PRE_ZERO;
                ms_d       = 10'd0;
                sec_d      = 6'd0;
                min_d      = 6'd0;
                disp_ms_d  = 10'd0;
                disp_sec_d = 6'd0;
                disp_min_d = 6'd0;
                ovf_d      = 1'b0;
            end
            default: begin
                pre_d = pre_q;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= PRE_ZERO;
            ms_q       <= 10'd0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            disp_ms_q  <= 10'd0;
            disp_sec_q <= 6'd0;
            disp_min_q <= 6'd0;
            ms_tick_q  <= 1'b0;
            s_tick_q   <= 1'b0;
            m_tick_q   <= 1'b0;
            running_q  <= 1'b0;
            lap_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            ms_q       <= ms_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            disp_ms_q  <= disp_ms_d;
            disp_sec_q <= disp_sec_d;
            disp_min_q <= disp_min_d;
            ms_tick_q  <= ms_tick_d;
            s_tick_q   <= s_tick_d;
            m_tick_q   <= m_tick_d;
            running_q  <= running_d;
            lap_q      <= lap_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ms_tick    = ms_tick_q;
    assign s_tick     = s_tick_q;
    assign m_tick     = m_tick_q;
    assign ms_cnt     = ms_q;
    assign sec_cnt    = sec_q;
    assign min_cnt    = min_q;
    assign disp_ms    = disp_ms_q;
    assign disp_sec   = disp_sec_q;
    assign disp_min   = disp_min_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase: main instance with TICK_DIV=4, plus a
// short-range instance (TICK_DIV=2, MIN_MAX=0) to reach the overflow wrap.
module tb_stopwatch_timebase;

    localparam logic [1:0] M_STOP  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_LAP   = 2'b10;
    localparam logic [1:0] M_PAUSE = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode, w_mode;

    logic       ms_tick, s_tick, m_tick, running, lap_active, ovf;
    logic [9:0] ms_cnt, disp_ms;
    logic [5:0] sec_cnt, min_cnt, disp_sec, disp_min;

    logic       w_ms_tick, w_s_tick, w_m_tick, w_running, w_lap_active, w_ovf;
    logic [9:0] w_ms_cnt, w_disp_ms;
    logic [5:0] w_sec_cnt, w_min_cnt, w_disp_sec, w_disp_min;

    int total = 0;
    int bad   = 0;
    int ms_seen, s_seen, pause_ticks, pause_moved, lap_moved;

    always #5 clk = ~clk;

    stopwatch_timebase #(.TICK_DIV(4), .MIN_MAX(59)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .ms_tick(ms_tick), .s_tick(s_tick), .m_tick(m_tick),
        .ms_cnt(ms_cnt), .sec_cnt(sec_cnt), .min_cnt(min_cnt),
        .disp_ms(disp_ms), .disp_sec(disp_sec), .disp_min(disp_min),
        .running(running), .lap_active(lap_active), .ovf(ovf)
    );

    stopwatch_timebase #(.TICK_DIV(2), .MIN_MAX(0)) dut_wrap (
        .clk(clk), .rst(rst), .mode(w_mode),
        .ms_tick(w_ms_tick), .s_tick(w_s_tick), .m_tick(w_m_tick),
        .ms_cnt(w_ms_cnt), .sec_cnt(w_sec_cnt), .min_cnt(w_min_cnt),
        .disp_ms(w_disp_ms), .disp_sec(w_disp_sec), .disp_min(w_disp_min),
        .running(w_running), .lap_active(w_lap_active), .ovf(w_ovf)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        mode   = M_STOP;
        w_mode = M_STOP;
        repeat (2) @(negedge clk);
        expect_eq("rst_ms",      32'(ms_cnt),     32'd0);
        expect_eq("rst_sec",     32'(sec_cnt),    32'd0);
        expect_eq("rst_min",     32'(min_cnt),    32'd0);
        expect_eq("rst_disp_ms", 32'(disp_ms),    32'd0);
        expect_eq("rst_ticks",   32'({ms_tick, s_tick, m_tick}), 32'd0);
        expect_eq("rst_flags",   32'({running, lap_active, ovf}), 32'd0);
        expect_eq("rst_w_ovf",   32'(w_ovf),      32'd0);
        rst = 1'b0;
        @(negedge clk);

        // STOP -> RUN, one full second of milliseconds
        mode    = M_RUN;
        ms_seen = 0;
        s_seen  = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            ms_seen += int'(ms_tick);
            s_seen  += int'(s_tick);
            if (i == 1) expect_eq("run_running", 32'(running), 32'd1);
            if (i == 3) expect_eq("no_tick_edge3", 32'(ms_tick), 32'd0);
            if (i == 4) begin
                expect_eq("first_tick_edge4", 32'(ms_tick), 32'd1);
                expect_eq("first_ms",         32'(ms_cnt),  32'd1);
            end
            if (i == 3999) expect_eq("ms_999", 32'(ms_cnt), 32'd999);
        end
        expect_eq("sec_ms_wrap",  32'(ms_cnt),   32'd0);
        expect_eq("sec_is_1",     32'(sec_cnt),  32'd1);
        expect_eq("ms_tick_cnt",  32'(ms_seen),  32'd1000);
        expect_eq("s_tick_cnt",   32'(s_seen),   32'd1);
        expect_eq("disp_lag_ms",  32'(disp_ms),  32'd999);
        expect_eq("disp_lag_sec", 32'(disp_sec), 32'd0);

        // Run on to 00:01.500 then a single STOP cycle
        repeat (2000) @(negedge clk);
        expect_eq("t1500_ms",  32'(ms_cnt),  32'd500);
        expect_eq("t1500_sec", 32'(sec_cnt), 32'd1);
        mode = M_STOP;
        @(negedge clk);
        expect_eq("stop_ms",       32'(ms_cnt),   32'd0);
        expect_eq("stop_sec",      32'(sec_cnt),  32'd0);
        expect_eq("stop_disp_ms",  32'(disp_ms),  32'd0);
        expect_eq("stop_disp_sec", 32'(disp_sec), 32'd0);
        expect_eq("stop_no_tick",  32'({ms_tick, s_tick, m_tick}), 32'd0);
        expect_eq("stop_running",  32'(running),  32'd0);

        // Pause/resume: 6 RUN edges leave prescaler at 2 with ms=1
        mode = M_RUN;
        repeat (6) @(negedge clk);
        expect_eq("pre_pause_ms", 32'(ms_cnt), 32'd1);
        mode        = M_PAUSE;
        pause_ticks = 0;
        pause_moved = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            pause_ticks += int'(ms_tick | s_tick | m_tick);
            if (ms_cnt != 10'd1) pause_moved++;
        end
        expect_eq("pause_ticks",   32'(pause_ticks), 32'd0);
        expect_eq("pause_moved",   32'(pause_moved), 32'd0);
        expect_eq("pause_disp_ms", 32'(disp_ms),     32'd1);
        expect_eq("pause_running", 32'(running),     32'd0);
        mode = M_RUN;
        @(negedge clk);
        expect_eq("resume1_ms",   32'(ms_cnt),  32'd1);
        expect_eq("resume1_tick", 32'(ms_tick), 32'd0);
        @(negedge clk);
        expect_eq("resume2_ms",   32'(ms_cnt),  32'd2);
        expect_eq("resume2_tick", 32'(ms_tick), 32'd1);

        // Lap freeze from ms=10
        mode = M_STOP;
        @(negedge clk);
        mode = M_RUN;
        repeat (40) @(negedge clk);
        expect_eq("prelap_ms",   32'(ms_cnt),  32'd10);
        expect_eq("prelap_disp", 32'(disp_ms), 32'd9);
        mode      = M_LAP;
        lap_moved = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (disp_ms != 10'd9) lap_moved++;
        end
        expect_eq("lap_disp_frozen", 32'(lap_moved),  32'd0);
        expect_eq("lap_live_ms",     32'(ms_cnt),     32'd20);
        expect_eq("lap_active",      32'(lap_active), 32'd1);
        expect_eq("lap_running",     32'(running),    32'd1);
        mode = M_RUN;
        @(negedge clk);
        expect_eq("lap_catchup", 32'(disp_ms),    32'd20);
        expect_eq("lap_off",     32'(lap_active), 32'd0);

        // Asynchronous reset in the middle of a count
        #2 rst = 1'b1;
        #1;
        expect_eq("arst_ms",      32'(ms_cnt),  32'd0);
        expect_eq("arst_disp",    32'(disp_ms), 32'd0);
        expect_eq("arst_running", 32'(running), 32'd0);
        repeat (2) @(negedge clk);
        expect_eq("arst_hold_ms",   32'(ms_cnt),  32'd0);
        expect_eq("arst_hold_tick", 32'(ms_tick), 32'd0);
        rst  = 1'b0;
        mode = M_STOP;
        expect_eq("main_ovf", 32'(ovf), 32'd0);

        // Wrap instance: run to 0:59.999, then one more ms overflows
        @(negedge clk);
        w_mode = M_RUN;
        for (int i = 1; i <= 119999; i++) begin
            @(negedge clk);
            if (i == 119999) begin
                expect_eq("w_pre_ms",  32'(w_ms_cnt),  32'd999);
                expect_eq("w_pre_sec", 32'(w_sec_cnt), 32'd59);
                expect_eq("w_pre_ovf", 32'(w_ovf),     32'd0);
            end
        end
        @(negedge clk);
        expect_eq("w_ticks", 32'({w_ms_tick, w_s_tick, w_m_tick}), 32'd7);
        expect_eq("w_ms",    32'(w_ms_cnt),  32'd0);
        expect_eq("w_sec",   32'(w_sec_cnt), 32'd0);
        expect_eq("w_min",   32'(w_min_cnt), 32'd0);
        expect_eq("w_ovf",   32'(w_ovf),     32'd1);
        w_mode = M_PAUSE;
        repeat (5) @(negedge clk);
        expect_eq("w_ovf_pause", 32'(w_ovf), 32'd1);
        w_mode = M_RUN;
        repeat (5) @(negedge clk);
        expect_eq("w_ovf_run", 32'(w_ovf), 32'd1);
        w_mode = M_STOP;
        @(negedge clk);
        expect_eq("w_ovf_stop", 32'(w_ovf),    32'd0);
        expect_eq("w_stop_ms",  32'(w_ms_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
- Responder to the stopwatch mode controller: consumes the controller's 2-bit mode code and produces the running time count.
- Produces the ms/s/m tick pulses that the controller consumes, plus a display value that freezes during lap.
- Sits between the mode controller and the 7-segment/display formatter.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick; must be >= 2.
- MIN_MAX, 59, last minute value before wrap; must be <= 63.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- mode  input  2  controller state: 00 STOP, 01 RUN, 10 LAP, 11 PAUSE.
- ms_tick  output  1  one-cycle pulse on each millisecond increment.
- s_tick  output  1  one-cycle pulse when ms wraps 999->0.
- m_tick  output  1  one-cycle pulse when sec wraps 59->0.
- ms_cnt  output  10  live milliseconds, 0..999.
- sec_cnt  output  6  live seconds, 0..59.
- min_cnt  output  6  live minutes, 0..MIN_MAX.
- disp_ms  output  10  display milliseconds.
- disp_sec  output  6  display seconds.
- disp_min  output  6  display minutes.
- running  output  1  1 when mode is RUN or LAP.
- lap_active  output  1  1 when mode is LAP.
- ovf  output  1  sticky flag: count wrapped past MIN_MAX:59.999.

Behaviour:
- Reset: rst high asynchronously clears all of the following to 0:
  - prescaler;
  - ms_cnt, sec_cnt, min_cnt;
  - disp_*;
  - all ticks;
  - ovf, running, lap_active.
- Reset mid-count behaves identically.
- All outputs are registered.
- running and lap_active are registered decodes of mode (1-cycle lag).
- Prescaler:
  - width is clog2(TICK_DIV); it advances only when mode is RUN or LAP.
  - On an edge with prescaler == TICK_DIV-1 and counting enabled:
    - prescaler <= 0;
    - ms_cnt increments;
    - ms_tick is high for the following cycle.
  - Otherwise prescaler increments and ms_tick is 0.
- Cascade on that same edge:
  - if ms_cnt == 999: ms_cnt <= 0, sec_cnt increments, s_tick pulses;
  - if additionally sec_cnt == 59: sec_cnt <= 0, min_cnt increments, m_tick pulses;
  - if additionally min_cnt == MIN_MAX: min_cnt <= 0 and ovf <= 1.
  - Simultaneous ticks are pulsed together in the same cycle.
- Mode STOP (00):
  - prescaler, live counters, disp_* and ovf are synchronously cleared each cycle;
  - no ticks.
- Mode RUN (01): counting; every cycle disp_* <= live values as of that edge's pre-update state, so the display lags the live count by 1 cycle.
- Mode LAP (10):
  - counting continues;
  - disp_* holds the value it had on the last edge with mode != LAP;
  - live outputs keep advancing.
- Mode PAUSE (11):
  - prescaler and counters hold; no ticks;
  - disp_* tracks the live (static) values.
- Transitions:
  - PAUSE->RUN resumes from the held prescaler value, with no lost or extra sub-ms cycles.
  - LAP->RUN: display catches up to live on the next edge.
  - STOP->RUN: first ms_tick appears TICK_DIV cycles after the first RUN edge.
  - Mode changes take effect on the edge at which the new code is sampled; no further qualification.
- Arithmetic: unsigned.
  - Live counters never exceed 999/59/MIN_MAX.
  - disp_* is only ever loaded from live values, so it is always in range.

Test Plan (TICK_DIV=4):
- Reset mid-count:
  - rst pulse asynchronous to clk while counters are nonzero -> all outputs 0 immediately, before the next edge;
  - remain 0 while rst is high.
- STOP->RUN:
  - hold RUN for 4000 cycles -> ms_cnt 999→0, sec_cnt=1, exactly 1000 ms_ticks and 1 s_tick;
  - first ms_tick is in the cycle after the 4th RUN edge.
- Pause/resume accuracy:
  - RUN 6 cycles, PAUSE 50 cycles, RUN 2 cycles -> ms_cnt=2;
  - no ticks during PAUSE;
  - counters constant.
- Lap freeze:
  - at ms_cnt=10 switch to LAP for 40 cycles -> disp_ms stays at its pre-LAP value while ms_cnt reaches 20;
  - back to RUN -> disp_ms=20 one cycle later.
- Wrap/overflow:
  - preload by running to MIN_MAX:59.999, then one more ms -> ms_tick, s_tick and m_tick all high in the same cycle;
  - all counters 0; ovf=1;
  - ovf stays 1 through PAUSE/RUN;
  - ovf clears on STOP.
- STOP clear:
  - RUN to 00:01.500, then STOP for 1 cycle -> live counters 0 after that edge;
  - disp 0; no tick emitted in the STOP cycle.
